// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary<->BCD converter.
// Digit count is derived from operand width via digits_f.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_e;

  localparam logic MODE_B2B = 1'b0;
  localparam logic MODE_D2B = 1'b1;
  localparam int   DIGIT_W  = 4;

  // ceil(log10(2^w)) approximation
  function automatic int digits_f(input int w);
    return ((w * 1233) >> 12) + 1;
  endfunction

endpackage

// File: rtl/bin_bcd_conv_if.sv
// Start/done request bundle between a client and the converter.
// master = client side, slave = converter side.
interface bin_bcd_conv_if
  import bcd_pkg::*;
#(
  parameter int BIN_W = 16
);

  localparam int BCD_W = DIGIT_W * digits_f(BIN_W);

  logic             start;
  logic             mode;
  logic [BIN_W-1:0] bin_in;
  logic [BCD_W-1:0] bcd_in;
  logic             ready;
  logic             busy;
  logic             done;
  logic             err;
  logic [BIN_W-1:0] bin_out;
  logic [BCD_W-1:0] bcd_out;

  modport master (
    output start, mode, bin_in, bcd_in,
    input  ready, busy, done, err,
    input  bin_out, bcd_out
  );

  modport slave (
    input  start, mode, bin_in, bcd_in,
    output ready, busy, done, err,
    output bin_out, bcd_out
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Per-digit dabble correction: +3 above 4 going to BCD,
// -3 at 8 and above coming back from BCD.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic               dir,
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (dir == MODE_B2B) begin
      if (din > 4'd4) dout = din + 4'd3;
    end else begin
      if (din >= 4'd8) dout = din - 4'd3;
    end
  end

endmodule

// File: rtl/bin_bcd_conv.sv
// Iterative bidirectional binary<->BCD converter, one bit
// per cycle through a shared scratch register.
module bin_bcd_conv
  import bcd_pkg::*;
#(
  parameter int BIN_W = 16
) (
  input logic            clk,
  input logic            reset,
  bin_bcd_conv_if.slave  io
);

  localparam int DIGITS = digits_f(BIN_W);
  localparam int BCD_W  = DIGIT_W * DIGITS;
  localparam int SCR_W  = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  state_e            state_q, state_d;
  logic [SCR_W-1:0]  scr_q, scr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic              err_int_q, err_int_d;
  logic              err_q, err_d;
  logic [BIN_W-1:0]  bin_out_q, bin_out_d;
  logic [BCD_W-1:0]  bcd_out_q, bcd_out_d;

  logic [SCR_W-1:0]  shr;
  logic [SCR_W-1:0]  iter;
  logic [BCD_W-1:0]  adj_in;
  logic [BCD_W-1:0]  adj_out;
  logic              bad_digit;

  assign shr    = scr_q >> 1;
  assign adj_in = (mode_q == MODE_D2B) ? shr[SCR_W-1:BIN_W]
                                       : scr_q[SCR_W-1:BIN_W];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .dir  (mode_q),
      .din  (adj_in[g*DIGIT_W +: DIGIT_W]),
      .dout (adj_out[g*DIGIT_W +: DIGIT_W])
    );
  end

  // B2B adjusts before the shift, D2B after it
  always_comb begin
    if (mode_q == MODE_D2B) iter = {adj_out, shr[BIN_W-1:0]};
    else                    iter = {adj_out, scr_q[BIN_W-1:0]} << 1;
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[BIN_W + i*DIGIT_W +: DIGIT_W] > 4'd9) bad_digit = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    scr_d     = scr_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    err_int_d = err_int_q;
    err_d     = err_q;
    bin_out_d = bin_out_q;
    bcd_out_d = bcd_out_q;
    unique case (state_q)
      IDLE: begin
        if (io.start) begin
          state_d = LOAD;
          mode_d  = io.mode;
          err_d   = 1'b0;
          if (io.mode == MODE_D2B) scr_d = {io.bcd_in, {BIN_W{1'b0}}};
          else                     scr_d = {{BCD_W{1'b0}}, io.bin_in};
        end
      end
      LOAD: begin
        state_d   = RUN;
        cnt_d     = CNT_W'(BIN_W);
        err_int_d = (mode_q == MODE_D2B) && bad_digit;
      end
      RUN: begin
        scr_d = iter;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          if (mode_q == MODE_B2B) begin
            bcd_out_d = iter[SCR_W-1:BIN_W];
            bin_out_d = '0;
            err_d     = 1'b0;
          end else begin
            bcd_out_d = '0;
            // leftover BCD weight means the value exceeds BIN_W bits
            if (err_int_q || (|iter[SCR_W-1:BIN_W])) begin
              err_d     = 1'b1;
              bin_out_d = '0;
            end else begin
              err_d     = 1'b0;
              bin_out_d = iter[BIN_W-1:0];
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      scr_q     <= '0;
      cnt_q     <= '0;
      mode_q    <= MODE_B2B;
      err_int_q <= 1'b0;
      err_q     <= 1'b0;
      bin_out_q <= '0;
      bcd_out_q <= '0;
    end else begin
      state_q   <= state_d;
      scr_q     <= scr_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      err_int_q <= err_int_d;
      err_q     <= err_d;
      bin_out_q <= bin_out_d;
      bcd_out_q <= bcd_out_d;
    end
  end

  assign io.ready   = (state_q == IDLE);
  assign io.busy    = (state_q == LOAD) || (state_q == RUN);
  assign io.done    = (state_q == DONE);
  assign io.err     = err_q;
  assign io.bin_out = bin_out_q;
  assign io.bcd_out = bcd_out_q;

endmodule
